vending_credit_ctrl: RTL and testbench

- Credit/change sequencer for the vending machine.
- Accepts coins one at a time and accumulates credit against a fixed price.
- Releases the item when the select button is pressed.
- Pays back any surplus coin-by-coin through a req/ack coin-ejector handshake.
- Drives the item-release datapath (ren) and the external coin ejector; replaces the separate change counter with an internal credit register.

---
 rtl/vending_credit_ctrl.sv | 159 +++++++++++++++
 tb/tb_vending_credit_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vending_credit_ctrl.sv
// Credit/change sequencer for the vending machine.
// Accumulates coin credit against PRICE, pulses ren on select, then pays the
// surplus back one coin at a time through the eject_req/eject_ack handshake.
// Optional build macro: VENDING_COIN_RETURN_EN adds a 'cancel' input that
// returns all credit without vending.
module vending_credit_ctrl #(
  parameter int unsigned PRICE = 100,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  input  logic          bp,
  input  logic          eject_ack,
`ifdef VENDING_COIN_RETURN_EN
  input  logic          cancel,
`endif
  output logic          coin_accept,
  output logic          coin_reject,
  output logic          ren,
  output logic          eject_req,
  output logic [1:0]    eject_coin,
  output logic [CW-1:0] credit,
  output logic [3:0]    state_o,
  output logic          busy
);

  // One-hot encoding doubles as the state_o bit assignment.
  typedef enum logic [3:0] {
    StCollect = 4'b0001,
    StRelease = 4'b0010,
    StChgReq  = 4'b0100,
    StChgGap  = 4'b1000
  } state_e;

  localparam logic [CW-1:0] PriceW = CW'(PRICE);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          accept_q, accept_d;
  logic          reject_q, reject_d;
  logic          ren_q, ren_d;
  logic          req_q, req_d;
  logic [1:0]    coin_q, coin_d;
  logic          busy_q, busy_d;
  logic          cancel_go;

  // Coin code to value in cents; ejector codes share the same encoding.
  function automatic logic [CW-1:0] coin_value(input logic [1:0] t);
    unique case (t)
      2'b00:   coin_value = CW'(5);
      2'b01:   coin_value = CW'(10);
      2'b10:   coin_value = CW'(25);
      default: coin_value = CW'(100);
    endcase
  endfunction

  // Largest ejectable coin not exceeding the remaining credit (never the dollar).
  function automatic logic [1:0] pick_coin(input logic [CW-1:0] c);
    if (c >= CW'(25))      pick_coin = 2'b10;
    else if (c >= CW'(10)) pick_coin = 2'b01;
    else                   pick_coin = 2'b00;
  endfunction

`ifdef VENDING_COIN_RETURN_EN
  assign cancel_go = cancel && !bp && (credit_q != '0);
`else
  assign cancel_go = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    accept_d = 1'b0;
    reject_d = coin_valid && (state_q != StCollect);
    ren_d    = 1'b0;
    req_d    = req_q;
    coin_d   = coin_q;
    unique case (state_q)
      StCollect: begin
        if (coin_valid) begin
          credit_d = credit_q + coin_value(coin_type);
          accept_d = 1'b1;
          if (credit_d >= PriceW) state_d = StRelease;
        end
        // Cancel returns everything, including a coin accepted on this edge.
        if (cancel_go) state_d = StChgReq;
      end
      StRelease: begin
        if (bp) begin
          ren_d    = 1'b1;
          credit_d = credit_q - PriceW;
          state_d  = StChgReq;
        end else if (cancel_go) begin
          state_d = StChgReq;
        end
      end
      StChgReq: begin
        if (req_q) begin
          if (eject_ack) begin
            credit_d = credit_q - coin_value(coin_q);
            req_d    = 1'b0;
            state_d  = StChgGap;
          end
        end else if (credit_q == '0) begin
          state_d = StCollect;
        end else begin
          req_d  = 1'b1;
          coin_d = pick_coin(credit_q);
        end
      end
      StChgGap: begin
        // Request for the next coin rises as we re-enter StChgReq.
        state_d = StChgReq;
        if (credit_q != '0) begin
          req_d  = 1'b1;
          coin_d = pick_coin(credit_q);
        end
      end
      default: state_d = StCollect;
    endcase
    busy_d = (state_d != StCollect);
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StCollect;
      credit_q <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      ren_q    <= 1'b0;
      req_q    <= 1'b0;
      coin_q   <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      ren_q    <= ren_d;
      req_q    <= req_d;
      coin_q   <= coin_d;
      busy_q   <= busy_d;
    end
  end

  assign coin_accept = accept_q;
  assign coin_reject = reject_q;
  assign ren         = ren_q;
  assign eject_req   = req_q;
  assign eject_coin  = coin_q;
  assign credit      = credit_q;
  assign state_o     = state_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Directed, table-driven bench for vending_credit_ctrl (PRICE=100, CW=8).
module tb_vending_credit_ctrl;

  localparam logic [3:0] SC = 4'b0001, SR = 4'b0010, SQ = 4'b0100, SG = 4'b1000;
  localparam logic [1:0] T5 = 2'b00, T10 = 2'b01, T25 = 2'b10, T100 = 2'b11;

  logic       clk = 1'b0;
  logic       reset, coin_valid, bp, eject_ack;
  logic [1:0] coin_type;
`ifdef VENDING_COIN_RETURN_EN
  logic       cancel;
`endif
  logic       coin_accept, coin_reject, ren, eject_req, busy;
  logic [1:0] eject_coin;
  logic [7:0] credit;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vending_credit_ctrl #(.PRICE(100), .CW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .bp          (bp),
    .eject_ack   (eject_ack),
`ifdef VENDING_COIN_RETURN_EN
    .cancel      (cancel),
`endif
    .coin_accept (coin_accept),
    .coin_reject (coin_reject),
    .ren         (ren),
    .eject_req   (eject_req),
    .eject_coin  (eject_coin),
    .credit      (credit),
    .state_o     (state_o),
    .busy        (busy)
  );

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] ct;
    logic       bp;
    logic       ack;
    logic       can;
    logic       acc;
    logic       rej;
    logic       ren;
    logic       req;
    logic [1:0] coin;
    logic [7:0] credit;
    logic [3:0] st;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic cv, input logic [1:0] ct,
                              input logic b, input logic ack, input logic can,
                              input logic acc, input logic rej, input logic rn,
                              input logic req, input logic [1:0] coin, input int cr,
                              input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.cv = cv; v.ct = ct; v.bp = b; v.ack = ack; v.can = can;
    v.acc = acc; v.rej = rej; v.ren = rn; v.req = req; v.coin = coin;
    v.credit = cr[7:0]; v.st = st;
    return v;
  endfunction

  // Drive one cycle of inputs, then check every output after the edge.
  task automatic apply(input vec_t v, input string name);
    logic [15:0] act, exp;
    logic        coin_ok;
    reset = v.rst; coin_valid = v.cv; coin_type = v.ct; bp = v.bp; eject_ack = v.ack;
`ifdef VENDING_COIN_RETURN_EN
    cancel = v.can;
`endif
    @(posedge clk);
    #1;
    act = {coin_accept, coin_reject, ren, eject_req, credit, state_o};
    exp = {v.acc, v.rej, v.ren, v.req, v.credit, v.st};
    // eject_coin is only defined while a request is up, and after reset.
    coin_ok = !(v.req || v.rst) || (eject_coin === v.coin);
    n_checks++;
    if (act !== exp || !coin_ok || busy !== (v.st != SC)) begin
      n_fail++;
      $display("FAIL %s: got acc=%b rej=%b ren=%b req=%b coin=%b credit=%0d state=%b busy=%b; want acc=%b rej=%b ren=%b req=%b coin=%b credit=%0d state=%b busy=%b",
               name, coin_accept, coin_reject, ren, eject_req, eject_coin, credit, state_o,
               busy, v.acc, v.rej, v.ren, v.req, v.coin, v.credit, v.st, (v.st != SC));
    end
  endtask

  vec_t tbl[$];
  vec_t idle_q;

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; bp = 1'b0; eject_ack = 1'b0;
`ifdef VENDING_COIN_RETURN_EN
    cancel = 1'b0;
`endif
    // Exact payment: four quarters, vend, no change.
    tbl.push_back(mk(1, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00,  25, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00,  50, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00,  75, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00, 100, SR));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00, 100, SR));
    tbl.push_back(mk(0, 0, 0,   1, 0, 0,  0, 0, 1, 0, 2'b00,   0, SQ));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC));
    // Overpay 175: reject in RELEASE, coin+bp together, three quarter ejects.
    tbl.push_back(mk(0, 1, T25,  0, 0, 0,  1, 0, 0, 0, 2'b00,  25, SC));
    tbl.push_back(mk(0, 1, T25,  0, 0, 0,  1, 0, 0, 0, 2'b00,  50, SC));
    tbl.push_back(mk(0, 1, T25,  0, 0, 0,  1, 0, 0, 0, 2'b00,  75, SC));
    tbl.push_back(mk(0, 1, T100, 0, 0, 0,  1, 0, 0, 0, 2'b00, 175, SR));
    tbl.push_back(mk(0, 1, T5,   0, 0, 0,  0, 1, 0, 0, 2'b00, 175, SR));
    tbl.push_back(mk(0, 1, T10,  1, 0, 0,  0, 1, 1, 0, 2'b00,  75, SQ));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2'b10,  75, SQ));
    tbl.push_back(mk(0, 0, 0,    0, 1, 0,  0, 0, 0, 0, 2'b00,  50, SG));
    tbl.push_back(mk(0, 0, 0,    0, 1, 0,  0, 0, 0, 1, 2'b10,  50, SQ)); // ack ignored in gap
    tbl.push_back(mk(0, 0, 0,    0, 1, 0,  0, 0, 0, 0, 2'b00,  25, SG));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2'b10,  25, SQ));
    tbl.push_back(mk(0, 0, 0,    0, 1, 0,  0, 0, 0, 0, 2'b00,   0, SG));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SQ));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC));
    // Mixed: 3 quarters + 2 dimes + quarter = 120, change as two dimes.
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00,  25, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00,  50, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00,  75, SC));
    tbl.push_back(mk(0, 1, T10, 0, 0, 0,  1, 0, 0, 0, 2'b00,  85, SC));
    tbl.push_back(mk(0, 1, T10, 0, 0, 0,  1, 0, 0, 0, 2'b00,  95, SC));
    tbl.push_back(mk(0, 1, T25, 0, 0, 0,  1, 0, 0, 0, 2'b00, 120, SR));
    tbl.push_back(mk(0, 0, 0,   1, 0, 0,  0, 0, 1, 0, 2'b00,  20, SQ));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 2'b01,  20, SQ));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0,  0, 0, 0, 0, 2'b00,  10, SG));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 2'b01,  10, SQ));
    tbl.push_back(mk(0, 0, 0,   0, 1, 0,  0, 0, 0, 0, 2'b00,   0, SG));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SQ));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Handshake hold for five cycles, one-cycle gap, then reset mid-change.
    apply(mk(1, 0, 0,    0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC), "hs_reset");
    apply(mk(0, 1, T25,  0, 0, 0,  1, 0, 0, 0, 2'b00,  25, SC), "hs_c1");
    apply(mk(0, 1, T25,  0, 0, 0,  1, 0, 0, 0, 2'b00,  50, SC), "hs_c2");
    apply(mk(0, 1, T25,  0, 0, 0,  1, 0, 0, 0, 2'b00,  75, SC), "hs_c3");
    apply(mk(0, 1, T100, 0, 0, 0,  1, 0, 0, 0, 2'b00, 175, SR), "hs_c4");
    apply(mk(0, 0, 0,    1, 0, 0,  0, 0, 1, 0, 2'b00,  75, SQ), "hs_vend");
    apply(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2'b10,  75, SQ), "hs_req");
    idle_q = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b10,  75, SQ);
    for (int k = 0; k < 5; k++) apply(idle_q, $sformatf("hs_hold%0d", k));
    apply(mk(0, 0, 0,    0, 1, 0,  0, 0, 0, 0, 2'b00,  50, SG), "hs_ack");
    apply(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 1, 2'b10,  50, SQ), "hs_rereq");
    apply(mk(1, 0, 0,    0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC), "hs_midreset");
    apply(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 0, 2'b00,   0, SC), "hs_after");

`ifdef VENDING_COIN_RETURN_EN
    // Cancel returns a dime then a nickel; cancel at zero credit does nothing.
    apply(mk(0, 1, T10, 0, 0, 0,  1, 0, 0, 0, 2'b00, 10, SC), "cx_dime");
    apply(mk(0, 1, T5,  0, 0, 0,  1, 0, 0, 0, 2'b00, 15, SC), "cx_nickel");
    apply(mk(0, 0, 0,   0, 0, 1,  0, 0, 0, 0, 2'b00, 15, SQ), "cx_cancel");
    apply(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 2'b01, 15, SQ), "cx_req1");
    apply(mk(0, 0, 0,   0, 1, 0,  0, 0, 0, 0, 2'b00,  5, SG), "cx_ack1");
    apply(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 2'b00,  5, SQ), "cx_req2");
    apply(mk(0, 0, 0,   0, 1, 0,  0, 0, 0, 0, 2'b00,  0, SG), "cx_ack2");
    apply(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,  0, SQ), "cx_done");
    apply(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,  0, SC), "cx_collect");
    apply(mk(0, 0, 0,   0, 0, 1,  0, 0, 0, 0, 2'b00,  0, SC), "cx_zero");
    apply(mk(0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 2'b00,  0, SC), "cx_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
